// File: rtl/conv_stream_if.sv
// Load/start/result bundle for conv_stream_engine; the host side drives through
// master and the engine uses slave.
interface conv_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
);
  logic                  in_valid;
  logic                  in_sel;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  start;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_data;
  logic                  out_last;

  modport master (
    output in_valid, in_sel, in_data, start, out_ready,
    input  in_ready, busy, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_sel, in_data, start, out_ready,
    output in_ready, busy, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_stream_engine.sv
// Sequential 2-D convolution: one MAC per cycle over each stride-spaced window,
// result held on a valid/ready port until taken.
module conv_stream_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int MATRIX_DIM = 16,
  parameter int CONV_DIM   = 3,
  parameter int STRIDE     = 1,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(CONV_DIM*CONV_DIM)
) (
  input logic          clk,
  input logic          rst,
  conv_stream_if.slave bus
);
  localparam int OUT_DIM = (MATRIX_DIM - CONV_DIM) / STRIDE + 1;
  localparam int KN      = CONV_DIM * CONV_DIM;
  localparam int MN      = MATRIX_DIM * MATRIX_DIM;
  localparam int KPW     = (KN > 1) ? $clog2(KN) : 1;
  localparam int MPW     = (MN > 1) ? $clog2(MN) : 1;
  localparam int CW      = (CONV_DIM > 1) ? $clog2(CONV_DIM) : 1;
  localparam int OW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  localparam logic [KPW-1:0] K_LAST = KPW'(KN - 1);
  localparam logic [MPW-1:0] M_LAST = MPW'(MN - 1);
  localparam logic [CW-1:0]  C_LAST = CW'(CONV_DIM - 1);
  localparam logic [OW-1:0]  O_LAST = OW'(OUT_DIM - 1);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
  state_t state, state_nxt;

  logic [KN-1:0][DATA_WIDTH-1:0] kmem;
  logic [MN-1:0][DATA_WIDTH-1:0] mmem;

  logic [KPW-1:0]          kptr;
  logic [MPW-1:0]          mptr;
  logic [CW-1:0]           kx, ky;
  logic [OW-1:0]           ox, oy;
  logic [ACC_WIDTH-1:0]    acc;
  logic [31:0]             row, col;
  logic [KPW-1:0]          kaddr;
  logic [MPW-1:0]          maddr;
  logic [2*DATA_WIDTH-1:0] prod;
  logic                    kdone, last_win;

  assign kdone    = (kx == C_LAST) && (ky == C_LAST);
  assign last_win = (ox == O_LAST) && (oy == O_LAST);

  // Combinational window read: matrix[oy*S+ky][ox*S+kx] against kernel[ky][kx]
  assign row   = 32'(oy) * 32'(STRIDE) + 32'(ky);
  assign col   = 32'(ox) * 32'(STRIDE) + 32'(kx);
  assign maddr = MPW'(row * 32'(MATRIX_DIM) + col);
  assign kaddr = KPW'(32'(ky) * 32'(CONV_DIM) + 32'(kx));
  assign prod  = kmem[kaddr] * mmem[maddr];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b1;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = acc;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.start) state_nxt = RUN;
      end
      RUN: if (kdone) state_nxt = OUT;
      OUT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_win;
        if (bus.out_ready) state_nxt = last_win ? IDLE : RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage is deliberately outside reset: contents survive rst and start
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      if (bus.in_sel) kmem[kptr] <= bus.in_data;
      else            mmem[mptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kptr <= '0;
      mptr <= '0;
      kx   <= '0;
      ky   <= '0;
      ox   <= '0;
      oy   <= '0;
      acc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Write lands at the old pointer; start then clears both pointers
          if (bus.start) begin
            kptr <= '0;
            mptr <= '0;
            kx   <= '0;
            ky   <= '0;
            ox   <= '0;
            oy   <= '0;
            acc  <= '0;
          end else if (bus.in_valid) begin
            if (bus.in_sel) kptr <= (kptr == K_LAST) ? '0 : kptr + 1'b1;
            else            mptr <= (mptr == M_LAST) ? '0 : mptr + 1'b1;
          end
        end
        RUN: begin
          acc <= acc + ACC_WIDTH'(prod);
          if (kx == C_LAST) begin
            kx <= '0;
            ky <= (ky == C_LAST) ? '0 : ky + 1'b1;
          end else begin
            kx <= kx + 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready && !last_win) begin
            acc <= '0;
            kx  <= '0;
            ky  <= '0;
            if (ox == O_LAST) begin
              ox <= '0;
              oy <= oy + 1'b1;
            end else begin
              ox <= ox + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
